rf_dbg_port: RTL and testbench

- Debug-side initiator for the miniRV register file: accepts debug commands (read one, write one, dump all) over a valid/ready stream.
- Halts the core, then drives the register file's write port and one read-address port.
- Returns read data / write acks over a valid/ready response stream.
- Sits between the debug transport and the rf/core, muxed onto the rf ports while the core is halted.

---
 rtl/rf_dbg_port_if.sv | 33 +++
 rtl/rf_dbg_port.sv | 241 ++++++++++++++++++++++++
 tb/tb_rf_dbg_port.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_dbg_port_if.sv
// Command/response stream bundle between the debug transport (master) and
// rf_dbg_port (slave).
interface rf_dbg_port_if #(
    parameter int ID_W = 5,
    parameter int XLEN = 32
);
    // Stream handshake rule for both directions: a transfer happens on the
    // rising clock edge where valid && ready are both high. A producer holds
    // its payload stable while valid is high and ready is low, and it does
    // not drop valid until the transfer has happened.
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [ID_W-1:0] cmd_addr;
    logic [XLEN-1:0] cmd_wdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_addr;
    logic [XLEN-1:0] rsp_data;
    logic            rsp_last;
    logic            rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_last, rsp_err
    );
endinterface

// File: rtl/rf_dbg_port.sv
// Debug initiator for the miniRV register file: halts the core, performs
// READ / WRITE / DUMP on the rf ports. Optional halt timeout: RF_DBG_TIMEOUT_EN.
module rf_dbg_port #(
    parameter int N_REGS         = 16,
    parameter int ID_W           = 5,
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clock,
    input  logic            reset,
    rf_dbg_port_if.slave    dbg,
    output logic            halt_req,
    input  logic            halt_ack,
    output logic            rf_wen,
    output logic [ID_W-1:0] rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic [ID_W-1:0] rf_rs,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_EXEC, S_RESP, S_RELEASE
    } state_t;

    localparam logic [1:0]      OP_WRITE = 2'b01;
    localparam logic [1:0]      OP_DUMP  = 2'b10;
    localparam logic [1:0]      OP_RSVD  = 2'b11;
    localparam logic [ID_W:0]   N_REGS_X = (ID_W+1)'(N_REGS);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REGS - 1);

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [ID_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [ID_W-1:0] cnt_q, cnt_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_last_q, rsp_last_d;
    logic            rsp_err_q, rsp_err_d;
    logic            halt_req_q, halt_req_d;
    logic            rf_wen_q, rf_wen_d;
    logic [ID_W-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [ID_W-1:0] rf_rs_q, rf_rs_d;
    logic            busy_q, busy_d;

`ifdef RF_DBG_TIMEOUT_EN
    localparam int            TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // cur_* describe the access being executed now; nxt_* the one about to be
    // launched when EXEC is entered (DUMP uses the counter, others the address).
    logic [ID_W-1:0] cur_idx, nxt_idx;
    logic            cur_ok, nxt_ok;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        halt_req_d  = halt_req_q;
        busy_d      = busy_q;
`ifdef RF_DBG_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        cur_idx = (op_q == OP_DUMP) ? cnt_q : addr_q;
        cur_ok  = ({1'b0, cur_idx} < N_REGS_X);

        case (state_q)
            S_IDLE: begin
                if (dbg.cmd_valid && cmd_ready_q) begin
                    op_d        = dbg.cmd_op;
                    addr_d      = dbg.cmd_addr;
                    wdata_d     = dbg.cmd_wdata;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    if (dbg.cmd_op == OP_RSVD) begin
                        // Bad op is answered without ever disturbing the core.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_addr_d  = dbg.cmd_addr;
                        rsp_data_d  = '0;
                        rsp_last_d  = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d    = S_HALT;
                        halt_req_d = 1'b1;
`ifdef RF_DBG_TIMEOUT_EN
                        tmo_d      = '0;
`endif
                    end
                end
            end
            S_HALT: begin
                if (halt_ack) begin
                    state_d = S_EXEC;
`ifdef RF_DBG_TIMEOUT_EN
                end else if (tmo_q == TMO_LAST) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_addr_d  = cur_idx;
                    rsp_data_d  = '0;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
`endif
                end
            end
            S_EXEC: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_addr_d  = cur_idx;
                rsp_err_d   = !cur_ok;
                rsp_last_d  = (op_q != OP_DUMP) || (cur_idx == LAST_IDX);
                // x0 always reads as zero, whatever the rf drives.
                rsp_data_d  = (op_q != OP_WRITE && cur_ok && cur_idx != '0)
                              ? rf_rdata : '0;
            end
            S_RESP: begin
                if (dbg.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_addr_d  = '0;
                    rsp_data_d  = '0;
                    rsp_last_d  = 1'b0;
                    rsp_err_d   = 1'b0;
                    if (op_q == OP_DUMP && !rsp_last_q) begin
                        cnt_d   = cnt_q + ID_W'(1);
                        state_d = S_EXEC;
                    end else begin
                        state_d    = S_RELEASE;
                        halt_req_d = 1'b0;
                    end
                end
            end
            S_RELEASE: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b1;
                busy_d      = 1'b0;
                halt_req_d  = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase

        // rf port values are registered on the way into EXEC so they are
        // valid for exactly the EXEC cycle and zero everywhere else.
        nxt_idx    = (op_q == OP_DUMP) ? cnt_d : addr_q;
        nxt_ok     = ({1'b0, nxt_idx} < N_REGS_X);
        rf_wen_d   = 1'b0;
        rf_rd_d    = '0;
        rf_wdata_d = '0;
        rf_rs_d    = '0;
        if (state_d == S_EXEC && nxt_ok) begin
            if (op_q == OP_WRITE) begin
                if (nxt_idx != '0) begin
                    rf_wen_d   = 1'b1;
                    rf_rd_d    = nxt_idx;
                    rf_wdata_d = wdata_q;
                end
            end else begin
                rf_rs_d = nxt_idx;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
            halt_req_q  <= 1'b0;
            rf_wen_q    <= 1'b0;
            rf_rd_q     <= '0;
            rf_wdata_q  <= '0;
            rf_rs_q     <= '0;
            busy_q      <= 1'b0;
`ifdef RF_DBG_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
            halt_req_q  <= halt_req_d;
            rf_wen_q    <= rf_wen_d;
            rf_rd_q     <= rf_rd_d;
            rf_wdata_q  <= rf_wdata_d;
            rf_rs_q     <= rf_rs_d;
            busy_q      <= busy_d;
`ifdef RF_DBG_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign dbg.cmd_ready = cmd_ready_q;
    assign dbg.rsp_valid = rsp_valid_q;
    assign dbg.rsp_addr  = rsp_addr_q;
    assign dbg.rsp_data  = rsp_data_q;
    assign dbg.rsp_last  = rsp_last_q;
    assign dbg.rsp_err   = rsp_err_q;
    assign halt_req      = halt_req_q;
    assign rf_wen        = rf_wen_q;
    assign rf_rd         = rf_rd_q;
    assign rf_wdata      = rf_wdata_q;
    assign rf_rs         = rf_rs_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_rf_dbg_port.sv
// Bench for rf_dbg_port: directed scenarios plus random commands, checked
// by a response scoreboard against a register-array reference model.
module tb_rf_dbg_port;
    localparam int N_REGS = 16;
    localparam int ID_W   = 5;
    localparam int XLEN   = 32;
`ifdef RF_DBG_TIMEOUT_EN
    localparam int TMO    = 8;
`else
    localparam int TMO    = 255;
`endif
    localparam int RW = 1 + ID_W + XLEN + 2;  // {halt_req, addr, data, last, err}
    localparam int WW = ID_W + XLEN;          // {rf_rd, rf_wdata}

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            halt_req, halt_ack, rf_wen, busy;
    logic [ID_W-1:0] rf_rd, rf_rs;
    logic [XLEN-1:0] rf_wdata, rf_rdata;

    rf_dbg_port_if #(.ID_W(ID_W), .XLEN(XLEN)) dbg ();

    rf_dbg_port #(.N_REGS(N_REGS), .ID_W(ID_W), .XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .dbg(dbg),
        .halt_req(halt_req), .halt_ack(halt_ack),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .rf_rs(rf_rs), .rf_rdata(rf_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0]   exp_q[$];
    logic [WW-1:0]   wr_q[$];
    logic [XLEN-1:0] rf_mem  [N_REGS];
    logic [XLEN-1:0] ref_regs[N_REGS];
    logic            force_rdata = 1'b0;
    int              rdy_mode = 0;

    // Environment register file: combinational read, written by the monitor.
    always_comb begin
        rf_rdata = '0;
        if (force_rdata) rf_rdata = 32'h0000_1234;
        else if (rf_rs < ID_W'(N_REGS)) rf_rdata = rf_mem[rf_rs[3:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [RW-1:0] pack_rsp(input logic h, input logic [ID_W-1:0] a,
                                               input logic [XLEN-1:0] d, input logic l, input logic e);
        return {h, a, d, l, e};
    endfunction

    // Reference model: decides every response from the command's meaning alone.
    task automatic model_cmd(input logic [1:0] op, input logic [ID_W-1:0] addr, input logic [XLEN-1:0] wdata);
        bit in_range = (addr < N_REGS);
        case (op)
            2'b00: exp_q.push_back(pack_rsp(1'b1, addr,
                       (in_range && addr != 0) ? ref_regs[addr[3:0]] : '0, 1'b1, !in_range));
            2'b01: begin
                exp_q.push_back(pack_rsp(1'b1, addr, '0, 1'b1, !in_range));
                if (in_range && addr != 0) begin
                    ref_regs[addr[3:0]] = wdata;
                    wr_q.push_back({addr, wdata});
                end
            end
            2'b10: for (int i = 0; i < N_REGS; i++)
                       exp_q.push_back(pack_rsp(1'b1, ID_W'(i), (i == 0) ? '0 : ref_regs[i],
                                                i == N_REGS - 1, 1'b0));
            default: exp_q.push_back(pack_rsp(1'b0, addr, '0, 1'b1, 1'b1));
        endcase
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send_cmd(input logic [1:0] op, input logic [ID_W-1:0] addr, input logic [XLEN-1:0] wdata);
        int n = 0;
        model_cmd(op, addr, wdata);
        dbg.cmd_valid = 1'b1;
        dbg.cmd_op    = op;
        dbg.cmd_addr  = addr;
        dbg.cmd_wdata = wdata;
        @(negedge clock);
        while (!dbg.cmd_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("cmd_accept_timeout", 64'(n >= 500), 64'd0);
        @(posedge clock);
        #1 dbg.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("idle_timeout", 64'(n >= 3000), 64'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic measure_latency(input string name);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!dbg.rsp_valid && n < 20);
        chk(name, 64'(n), 64'd3);
    endtask

    // Response ready pattern: 0 always, 1 toggling, 2 random, 3 held low.
    initial begin
        dbg.rsp_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0:       dbg.rsp_ready = 1'b1;
                1:       dbg.rsp_ready = ~dbg.rsp_ready;
                2:       dbg.rsp_ready = 1'($urandom_range(0, 1));
                default: dbg.rsp_ready = 1'b0;
            endcase
        end
    end

    // Monitor: response scoreboard, hold stability, release cycle, rf writes.
    initial begin
        logic          rel_pend = 1'b0;
        logic          hold = 1'b0;
        logic [RW-1:0] held = '0;
        logic [RW-1:0] cur, exp;
        forever begin
            @(negedge clock);
            if (reset) begin
                rel_pend = 1'b0;
                hold = 1'b0;
                continue;
            end
            cur = pack_rsp(halt_req, dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last, dbg.rsp_err);
            if (rel_pend) begin
                chk("release_cycle", {61'd0, halt_req, dbg.cmd_ready, busy}, 64'b001);
                rel_pend = 1'b0;
            end
            if (hold && dbg.rsp_valid) chk("rsp_stable", 64'(cur), 64'(held));
            hold = dbg.rsp_valid && !dbg.rsp_ready;
            held = cur;
            if (dbg.rsp_valid && dbg.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'(cur), 64'd0);
                end else begin
                    exp = exp_q.pop_front();
                    chk("rsp", 64'(cur), 64'(exp));
                    if (dbg.rsp_last) rel_pend = 1'b1;
                end
            end
            if (rf_wen) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_rf_wen", {27'd0, rf_rd, rf_wdata}, 64'd0);
                end else begin
                    chk("rf_write", {27'd0, rf_rd, rf_wdata}, 64'(wr_q.pop_front()));
                end
                if (rf_rd < ID_W'(N_REGS)) rf_mem[rf_rd[3:0]] = rf_wdata;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic            flag;
        logic [1:0]      op;
        logic [ID_W-1:0] addr;
        for (int i = 0; i < N_REGS; i++) begin
            rf_mem[i]   = $urandom;
            ref_regs[i] = rf_mem[i];
        end
        dbg.cmd_valid = 1'b0;
        dbg.cmd_op    = '0;
        dbg.cmd_addr  = '0;
        dbg.cmd_wdata = '0;
        halt_ack      = 1'b1;

        repeat (3) @(negedge clock);
        chk("reset_ctrl", {59'd0, dbg.cmd_ready, dbg.rsp_valid, halt_req, busy, rf_wen}, 64'b10000);
        chk("reset_rsp", 64'(pack_rsp(1'b0, dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last, dbg.rsp_err)), 64'd0);
        chk("reset_rf", {27'd0, rf_rd | rf_rs, rf_wdata}, 64'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Basic write then read-back, with the 3-cycle latency.
        send_cmd(2'b01, 5'd3, 32'hDEAD_BEEF);
        measure_latency("write_latency");
        wait_idle();
        send_cmd(2'b00, 5'd3, '0);
        measure_latency("read_latency");
        wait_idle();

        // x0 reads as zero even when the rf drives something else.
        force_rdata = 1'b1;
        send_cmd(2'b00, 5'd0, '0);
        wait_idle();
        force_rdata = 1'b0;

        // Full dump under a toggling consumer.
        rdy_mode = 1;
        send_cmd(2'b10, 5'd0, '0);
        wait_idle();
        rdy_mode = 0;

        // Errors and no-ops: none may touch the rf; reserved op never halts.
        send_cmd(2'b01, 5'd20, 32'h1111_2222);
        wait_idle();
        send_cmd(2'b00, 5'd17, '0);
        wait_idle();
        send_cmd(2'b01, 5'd0, 32'h3333_4444);
        wait_idle();
        send_cmd(2'b11, 5'd7, 32'h5555_6666);
        flag = 1'b0;
        repeat (6) begin
            @(negedge clock);
            flag = flag | halt_req;
        end
        chk("reserved_no_halt", 64'(flag), 64'd0);
        wait_idle();

        // Late halt_ack: EXEC must follow the cycle the ack rises.
        halt_ack = 1'b0;
        send_cmd(2'b01, 5'd5, 32'hA5A5_0F0F);
        flag = 1'b0;
        repeat (10) begin
            @(negedge clock);
            flag = flag | rf_wen | !halt_req;
        end
        chk("wait_for_ack", 64'(flag), 64'd0);
        @(posedge clock);
        #1 halt_ack = 1'b1;
        @(negedge clock);
        chk("ack_cycle_no_wen", 64'(rf_wen), 64'd0);
        @(negedge clock);
        chk("exec_after_ack", 64'(rf_wen), 64'd1);
        wait_idle();

`ifdef RF_DBG_TIMEOUT_EN
        halt_ack = 1'b0;
        exp_q.push_back(pack_rsp(1'b1, 5'd4, '0, 1'b1, 1'b1));
        dbg.cmd_valid = 1'b1;
        dbg.cmd_op    = 2'b00;
        dbg.cmd_addr  = 5'd4;
        @(posedge clock);
        #1 dbg.cmd_valid = 1'b0;
        wait_idle();
        halt_ack = 1'b1;
`endif

        // Random traffic with a random consumer.
        rdy_mode = 2;
        for (int k = 0; k < 40; k++) begin
            int r = $urandom_range(0, 9);
            op   = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            addr = ($urandom_range(0, 7) == 0) ? ID_W'($urandom_range(N_REGS, 31))
                                               : ID_W'($urandom_range(0, N_REGS - 1));
            send_cmd(op, addr, $urandom);
        end
        wait_idle();

        // Reset while a DUMP response is pending.
        rdy_mode = 3;
        send_cmd(2'b10, 5'd0, '0);
        begin
            int n = 0;
            while (!dbg.rsp_valid && n < 50) begin
                @(negedge clock);
                n++;
            end
            chk("dump_rsp_seen", 64'(dbg.rsp_valid), 64'd1);
        end
        #2 reset = 1'b1;
        #1;
        chk("midop_reset_ctrl", {59'd0, dbg.cmd_ready, dbg.rsp_valid, halt_req, busy, rf_wen}, 64'b10000);
        chk("midop_reset_rsp", 64'(pack_rsp(1'b0, dbg.rsp_addr, dbg.rsp_data, dbg.rsp_last, dbg.rsp_err)), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        rdy_mode = 0;
        @(posedge clock);
        #1;
        send_cmd(2'b00, 5'd3, '0);
        measure_latency("post_reset_latency");
        wait_idle();

        chk("writes_all_seen", 64'(wr_q.size()), 64'd0);
        chk("rsp_all_seen", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
